sram_audio_reader: RTL and testbench
====================================

# sram_audio_reader

Playback-side reader that sits directly downstream of the 16-bit SRAM controller in the SD-card audio path. It walks a programmable address window of the SRAM, fetches one 16-bit PCM sample per read, and buffers the samples in a small FIFO. It hands samples to the audio DAC serializer on a per-sample request pulse, with optional looping and underrun reporting.

## Interface
Parameters:
- ADDR_W, 18, SRAM word-address width
- START_ADDR, 18'h00000, first sample word address
- END_ADDR, 18'h3FFFF, last sample word address (inclusive); must be ≥ START_ADDR
- RD_WAIT, 2, cycles CE_N/OE_N are held low per read; data is captured on the last one (≥1)
- FIFO_DEPTH, 4, sample buffer depth, power of two

Ports:
- iCLK  in  1  system clock; sole clock domain
- iRST  in  1  asynchronous, active-high reset
- iSTART  in  1  single-cycle pulse: begin playback from START_ADDR; ignored while oBUSY=1
- iSTOP  in  1  single-cycle pulse: abort playback and flush FIFO
- iLOOP  in  1  level, sampled at the END_ADDR capture: 1 = wrap to START_ADDR
- iSAMPLE_REQ  in  1  single-cycle pulse from DAC serializer: one sample wanted
- oSAMPLE  out  16  sample returned for the last request
- oSAMPLE_VALID  out  1  one-cycle pulse, oSAMPLE valid
- oUNDERRUN  out  1  one-cycle pulse: request arrived with FIFO empty during active playback
- oBUSY  out  1  high from accepted iSTART until return to IDLE
- oSRAM_ADDR  out  ADDR_W  to controller iADDR
- oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N  out  1 each  to controller iCE_N/iOE_N/iWE_N; WE_N is constant 1
- oSRAM_BE_N  out  2  to controller iBE_N; constant 2'b00 (both bytes)
- iSRAM_DATA  in  16  from controller oDATA

## Operation
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: CE_N=OE_N=1, FIFO empty, oBUSY=0. On iSTART: set address to START_ADDR, oBUSY=1, go to FETCH.
- FETCH: CE_N=OE_N=0, address stable. The wait counter runs 0..RD_WAIT-1. On the last count, push iSRAM_DATA into the FIFO, then:
  - address == END_ADDR and iLOOP=1: address → START_ADDR, continue.
  - address == END_ADDR and iLOOP=0: go to DRAIN.
  - otherwise: address +1.
  - The next state is FETCH if FIFO occupancy after this cycle's push/pop is < FIFO_DEPTH, else HOLD.
- HOLD: CE_N=OE_N=1, address held. Return to FETCH on the first cycle occupancy < FIFO_DEPTH.
- DRAIN: CE_N=OE_N=1, no fetches. When the FIFO is empty and no pop is in progress, go to IDLE and drop oBUSY.
- Request handling, any state:
  - iSAMPLE_REQ with FIFO non-empty: pop; next cycle oSAMPLE = popped word, oSAMPLE_VALID=1.
  - Empty in FETCH/HOLD: next cycle oSAMPLE=0, oSAMPLE_VALID=1, oUNDERRUN=1.
  - Empty in DRAIN/IDLE: oSAMPLE=0, oSAMPLE_VALID=1, no underrun.
- Simultaneous push and pop: both take effect; occupancy is unchanged.
- iSTOP, any state: next cycle IDLE, CE_N=OE_N=1, FIFO flushed, oBUSY=0. A request in the same cycle returns 0 without underrun. iSTOP wins over a same-cycle iSTART.

## Timing
- Reset values: oSRAM_ADDR=START_ADDR, CE_N=OE_N=WE_N=1, BE_N=2'b00, oSAMPLE=0, oSAMPLE_VALID=0, oUNDERRUN=0, oBUSY=0, FIFO empty, state IDLE. A mid-playback reset returns to exactly these values immediately.
- iSTART sampled at edge N: CE_N/OE_N low from N+1. First capture at the end of cycle N+RD_WAIT. The word is poppable from N+RD_WAIT+1.
- Back-to-back fetches: the address changes every RD_WAIT cycles with CE_N/OE_N held low. Throughput is one word per RD_WAIT cycles.
- Request→oSAMPLE_VALID latency: exactly 1 cycle. Requests may arrive on consecutive cycles.
- oSRAM_ADDR, CE_N and OE_N are registered; they change only on iCLK edges.

## Structure
- Package sram_audio_pkg holds the state enum (IDLE/FETCH/HOLD/DRAIN), the sample width constant (16), and the BE_N constant 2'b00.
- One sub-module: audio_sample_fifo. It is a synchronous FIFO, parameterised by depth, with push/pop/flush inputs, a count output, and full/empty flags.

## Test plan
- START_ADDR=0x10, END_ADDR=0x13, iLOOP=0, SRAM model returns addr+0x100. iSTART, then requests every 8 cycles → samples 0x110, 0x111, 0x112, 0x113, then 0x0000 with no underrun; oBUSY falls after the 4th pop.
- Same window with iLOOP=1 and 10 requests → 0x110..0x113, 0x110..0x113, 0x110, 0x111; address wraps 0x13→0x10.
- FIFO_DEPTH=4 with no requests for 50 cycles → exactly 4 fetches, then HOLD with CE_N/OE_N=1. One request → one more fetch begins on the next cycle.
- Requests every cycle with RD_WAIT=2 → FIFO empties; oUNDERRUN pulses with oSAMPLE=0 while data order is preserved.
- iSTOP mid-FETCH with the FIFO holding 2 words → next cycle IDLE, CE_N=1, oBUSY=0; a following request returns 0 without underrun.
- iRST asserted mid-FETCH → all outputs at reset values asynchronously; a later iSTART restarts from START_ADDR.

Source files
------------

// File: rtl/sram_audio_reader_pkg.sv
// Shared types and constants for the SRAM playback reader.
package sram_audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int         SAMPLE_W  = 16;
  localparam logic [1:0] SRAM_BE_N = 2'b00;

endpackage

// File: rtl/sram_audio_reader_if.sv
// Read-side bus between the playback reader and the 16-bit SRAM controller.
interface sram_audio_reader_if #(
  parameter int ADDR_W = 18
);
  import sram_audio_pkg::*;

  logic [ADDR_W-1:0]   oSRAM_ADDR;
  logic                oSRAM_CE_N;
  logic                oSRAM_OE_N;
  logic                oSRAM_WE_N;
  logic [1:0]          oSRAM_BE_N;
  logic [SAMPLE_W-1:0] iSRAM_DATA;

  modport master (
    output oSRAM_ADDR,
    output oSRAM_CE_N,
    output oSRAM_OE_N,
    output oSRAM_WE_N,
    output oSRAM_BE_N,
    input  iSRAM_DATA
  );

  modport slave (
    input  oSRAM_ADDR,
    input  oSRAM_CE_N,
    input  oSRAM_OE_N,
    input  oSRAM_WE_N,
    input  oSRAM_BE_N,
    output iSRAM_DATA
  );

endinterface

// File: rtl/sram_audio_reader_fifo.sv
// Synchronous sample FIFO; DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module audio_sample_fifo
  import sram_audio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic [SAMPLE_W-1:0] rdata,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [SAMPLE_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_audio_reader.sv
// Walks an SRAM address window, buffers one 16-bit PCM sample per read and serves DAC requests.
//   state | meaning
//   IDLE  | stopped, SRAM deselected, FIFO empty
//   FETCH | read cycle in progress, CE_N/OE_N low
//   HOLD  | FIFO full, waiting for room before the next read
//   DRAIN | window finished without loop, emptying FIFO
module sram_audio_reader
  import sram_audio_pkg::*;
#(
  parameter int                ADDR_W     = 18,
  parameter logic [ADDR_W-1:0] START_ADDR = 18'h00000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 18'h3FFFF,
  parameter int                RD_WAIT    = 2,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iSTART,
  input  logic                iSTOP,
  input  logic                iLOOP,
  input  logic                iSAMPLE_REQ,
  output logic [SAMPLE_W-1:0] oSAMPLE,
  output logic                oSAMPLE_VALID,
  output logic                oUNDERRUN,
  output logic                oBUSY,
  sram_audio_reader_if.master sram
);

  localparam int                WAIT_W    = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_WAIT - 1);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                ce_n_q, ce_n_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                underrun_q, underrun_d;

  logic                capture, push, pop;
  logic [SAMPLE_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]    fifo_count, occ_next;
  logic                fifo_full, fifo_empty;

  // Read data is taken on the terminal count of the per-read down-counter.
  assign capture  = (state_q == FETCH) && (wait_q == '0);
  assign push     = capture && !iSTOP && !fifo_full;
  assign pop      = iSAMPLE_REQ && !fifo_empty && !iSTOP;
  assign occ_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRST),
    .push  (push),
    .pop   (pop),
    .flush (iSTOP),
    .wdata (sram.iSRAM_DATA),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    if (iSTOP) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (iSTART) begin
            state_d = FETCH;
            addr_d  = START_ADDR;
            wait_d  = WAIT_LOAD;
          end
        end
        FETCH: begin
          if (capture) begin
            if ((addr_q == END_ADDR) && !iLOOP) begin
              state_d = DRAIN;
            end else begin
              addr_d  = (addr_q == END_ADDR) ? START_ADDR : addr_q + 1'b1;
              wait_d  = WAIT_LOAD;
              state_d = (occ_next < DEPTH_C) ? FETCH : HOLD;
            end
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end
        HOLD: begin
          if (occ_next < DEPTH_C) begin
            state_d = FETCH;
            wait_d  = WAIT_LOAD;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // An empty-FIFO request only counts as underrun while playback is still fetching.
  always_comb begin
    ce_n_d     = (state_d != FETCH);
    sample_d   = pop ? fifo_rdata : '0;
    valid_d    = iSAMPLE_REQ;
    underrun_d = iSAMPLE_REQ && fifo_empty && !iSTOP
                 && ((state_q == FETCH) || (state_q == HOLD));
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      addr_q     <= START_ADDR;
      wait_q     <= WAIT_LOAD;
      ce_n_q     <= 1'b1;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wait_q     <= wait_d;
      ce_n_q     <= ce_n_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign oSAMPLE         = sample_q;
  assign oSAMPLE_VALID   = valid_q;
  assign oUNDERRUN       = underrun_q;
  assign oBUSY           = (state_q != IDLE);
  assign sram.oSRAM_ADDR = addr_q;
  assign sram.oSRAM_CE_N = ce_n_q;
  assign sram.oSRAM_OE_N = ce_n_q;
  assign sram.oSRAM_WE_N = 1'b1;
  assign sram.oSRAM_BE_N = SRAM_BE_N;

endmodule

// File: tb/tb_sram_audio_reader.sv
// Bench for sram_audio_reader: directed playback scenarios plus randomized request streams.
module tb_sram_audio_reader;
  import sram_audio_pkg::*;

  localparam int          RD_WAIT = 2;
  localparam int          DEPTH   = 4;
  localparam logic [17:0] S_ADDR  = 18'h10;
  localparam logic [17:0] E_ADDR  = 18'h13;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, loop = 1'b0, req = 1'b0;
  logic [15:0] sample;
  logic        valid, underrun, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_cycles = 0;

  sram_audio_reader_if #(.ADDR_W(18)) sram_bus ();
  assign sram_bus.iSRAM_DATA = 16'(sram_bus.oSRAM_ADDR + 18'h100);

  sram_audio_reader #(
    .ADDR_W     (18),
    .START_ADDR (S_ADDR),
    .END_ADDR   (E_ADDR),
    .RD_WAIT    (RD_WAIT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .iCLK          (clk),
    .iRST          (rst),
    .iSTART        (start),
    .iSTOP         (stop),
    .iLOOP         (loop),
    .iSAMPLE_REQ   (req),
    .oSAMPLE       (sample),
    .oSAMPLE_VALID (valid),
    .oUNDERRUN     (underrun),
    .oBUSY         (busy),
    .sram          (sram_bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // k-th word of the playback stream: the window is read in order, wrapping when looping.
  function automatic logic [15:0] word_at(input int k);
    int n;
    n = int'(E_ADDR - S_ADDR) + 1;
    return 16'(int'(S_ADDR) + 'h100 + (k % n));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    if (sram_bus.oSRAM_CE_N === 1'b0) ce_cycles++;
  endtask

  task automatic pulse_req();
    req = 1'b1;
    cyc();
    req = 1'b0;
  endtask

  task automatic do_start(input logic lp);
    loop  = lp;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, ur, gap;

    #1 rst = 1'b1;
    #2;
    check_eq("rst_ce_n",   sram_bus.oSRAM_CE_N, 1);
    check_eq("rst_oe_n",   sram_bus.oSRAM_OE_N, 1);
    check_eq("rst_we_n",   sram_bus.oSRAM_WE_N, 1);
    check_eq("rst_be_n",   sram_bus.oSRAM_BE_N, 0);
    check_eq("rst_addr",   sram_bus.oSRAM_ADDR, S_ADDR);
    check_eq("rst_sample", sample, 0);
    check_eq("rst_valid",  valid, 0);
    check_eq("rst_ur",     underrun, 0);
    check_eq("rst_busy",   busy, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Single pass, no loop, slow requests.
    do_start(1'b0);
    check_eq("s1_ce_first", sram_bus.oSRAM_CE_N, 0);
    check_eq("s1_addr0",    sram_bus.oSRAM_ADDR, S_ADDR);
    check_eq("s1_busy",     busy, 1);
    repeat (RD_WAIT) cyc();
    check_eq("s1_addr1",    sram_bus.oSRAM_ADDR, S_ADDR + 18'd1);
    repeat (7 - RD_WAIT) cyc();
    for (int i = 0; i < 5; i++) begin
      if (i == 3) check_eq("s1_busy_pre4", busy, 1);
      pulse_req();
      check_eq("s1_valid", valid, 1);
      check_eq("s1_ur",    underrun, 0);
      check_eq("s1_sample", sample, (i < 4) ? 32'(word_at(i)) : 32'd0);
      if (i == 3) begin
        repeat (2) cyc();
        check_eq("s1_busy_post4", busy, 0);
        check_eq("s1_ce_idle", sram_bus.oSRAM_CE_N, 1);
        repeat (5) cyc();
      end else if (i < 3) begin
        repeat (7) cyc();
      end
    end
    repeat (3) cyc();

    // Looping playback, 10 slow requests.
    do_start(1'b1);
    repeat (7) cyc();
    for (int i = 0; i < 10; i++) begin
      pulse_req();
      check_eq("s2_sample", sample, word_at(i));
      check_eq("s2_ur", underrun, 0);
      repeat (7) cyc();
    end
    do_stop();

    // FIFO fills and holds; one request releases exactly one more read.
    ce_cycles = 0;
    do_start(1'b1);
    repeat (50) cyc();
    check_eq("s3_fetch_cycles", ce_cycles, DEPTH * RD_WAIT);
    check_eq("s3_hold_ce",  sram_bus.oSRAM_CE_N, 1);
    check_eq("s3_hold_oe",  sram_bus.oSRAM_OE_N, 1);
    check_eq("s3_busy",     busy, 1);
    ce_cycles = 0;
    pulse_req();
    check_eq("s3_refetch_ce",   sram_bus.oSRAM_CE_N, 0);
    check_eq("s3_refetch_addr", sram_bus.oSRAM_ADDR, S_ADDR);
    check_eq("s3_sample",       sample, word_at(0));
    repeat (20) cyc();
    check_eq("s3_one_more", ce_cycles, RD_WAIT);
    do_stop();

    // Randomized slow requests: fetcher keeps up, stream must be exact.
    do_start(1'b1);
    gap = $urandom_range(RD_WAIT + 1, 12);
    for (int i = 0; i < 20; i++) begin
      repeat (gap - 1) cyc();
      pulse_req();
      check_eq("r1_valid",  valid, 1);
      check_eq("r1_ur",     underrun, 0);
      check_eq("r1_sample", sample, word_at(i));
      gap = $urandom_range(RD_WAIT, 7);
    end
    do_stop();

    // Back-to-back requests: underruns return zero, data order is preserved.
    do_start(1'b1);
    repeat ($urandom_range(0, 3)) cyc();
    k  = 0;
    ur = 0;
    req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      check_eq("r2_valid", valid, 1);
      if (underrun) begin
        ur++;
        check_eq("r2_ur_zero", sample, 0);
      end else begin
        check_eq("r2_stream", sample, word_at(k));
        k++;
      end
    end
    req = 1'b0;
    cyc();
    check_eq("r2_ur_seen",   (ur > 0) ? 1 : 0, 1);
    check_eq("r2_data_seen", (k > 10) ? 1 : 0, 1);
    do_stop();

    // Stop mid-fetch with two words buffered.
    do_start(1'b0);
    repeat (2 * RD_WAIT) cyc();
    check_eq("s5_in_fetch", sram_bus.oSRAM_CE_N, 0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check_eq("s5_busy", busy, 0);
    check_eq("s5_ce",   sram_bus.oSRAM_CE_N, 1);
    pulse_req();
    check_eq("s5_valid",  valid, 1);
    check_eq("s5_sample", sample, 0);
    check_eq("s5_ur",     underrun, 0);
    cyc();

    // Stop beats a same-cycle start; same-cycle request gets zero, no underrun.
    start = 1'b1;
    stop  = 1'b1;
    req   = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    req   = 1'b0;
    check_eq("s6_busy",   busy, 0);
    check_eq("s6_sample", sample, 0);
    check_eq("s6_ur",     underrun, 0);
    cyc();
    check_eq("s6_ce", sram_bus.oSRAM_CE_N, 1);

    // Asynchronous reset mid-fetch, then restart.
    do_start(1'b0);
    repeat (RD_WAIT) cyc();
    req = 1'b1;
    cyc();
    req = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_eq("s7_ce",     sram_bus.oSRAM_CE_N, 1);
    check_eq("s7_busy",   busy, 0);
    check_eq("s7_addr",   sram_bus.oSRAM_ADDR, S_ADDR);
    check_eq("s7_valid",  valid, 0);
    check_eq("s7_sample", sample, 0);
    #1 rst = 1'b0;
    cyc();
    do_start(1'b0);
    check_eq("s7_restart_addr", sram_bus.oSRAM_ADDR, S_ADDR);
    check_eq("s7_restart_ce",   sram_bus.oSRAM_CE_N, 0);
    repeat (RD_WAIT) cyc();
    pulse_req();
    check_eq("s7_first_word", sample, word_at(0));
    do_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
